// File: rtl/interrupt_controller.sv
// Interrupt controller: INTCON/PIR1/PIE1 flag and enable registers, RB0/INT edge
// detection and the IDLE/ARM/REQ/SERVICE request sequencer towards the core.
module interrupt_controller (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       Sync,
    input  logic [8:0] Address,
    input  logic [7:0] Data,
    input  logic       Latch,
    input  logic       T0IE,
    input  logic       T0IF,
    input  logic       INTPin,
    input  logic       RBChange,
    input  logic [7:0] PeriphSet,
    input  logic       IntAck,
    input  logic       Retfie,
    output logic [7:0] INTCON,
    output logic [7:0] PIR1,
    output logic [7:0] PIE1,
    output logic       INTEDG,
    output logic       IntReq,
    output logic       Wake
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        REQ     = 2'd2,
        SERVICE = 2'd3
    } state_t;

    state_t state_r;
    state_t next_state_s;

    logic gie_r;
    logic peie_r;
    logic inte_r;
    logic rbie_r;
    logic intf_r;
    logic rbif_r;

    logic pin_meta_r;
    logic pin_sync_r;
    logic pin_prev_r;

    logic wr_intcon_s;
    logic wr_intedg_s;
    logic wr_pir1_s;
    logic wr_pie1_s;
    logic int_edge_s;
    logic pending_s;
    logic ack_s;
    logic ret_s;

    // INTCON is mirrored in every bank, so its decode ignores Address[8:7].
    assign wr_intcon_s = Latch & ((Address & 9'h07F) == 9'h00B);
    assign wr_intedg_s = Latch & ((Address & 9'h0FF) == 9'h081);
    assign wr_pir1_s   = Latch & ((Address & 9'h0FF) == 9'h00C);
    assign wr_pie1_s   = Latch & ((Address & 9'h0FF) == 9'h08C);

    assign int_edge_s = INTEDG ? (pin_sync_r & ~pin_prev_r)
                               : (~pin_sync_r & pin_prev_r);

    assign pending_s = (T0IE & T0IF)
                     | (inte_r & intf_r)
                     | (rbie_r & rbif_r)
                     | (peie_r & (|(PIE1 & PIR1)));

    assign ack_s = IntAck & (state_r == REQ);
    assign ret_s = Retfie & (state_r == SERVICE);

    assign Wake   = pending_s;
    assign INTCON = {gie_r, peie_r, T0IE, inte_r, rbie_r, T0IF, intf_r, rbif_r};

    // Next-state logic of the request sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (gie_r & pending_s) begin
                    next_state_s = ARM;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ARM: begin
                if (!(gie_r & pending_s)) begin
                    next_state_s = IDLE;
                end else if (Sync) begin
                    next_state_s = REQ;
                end else begin
                    next_state_s = ARM;
                end
            end
            REQ: begin
                if (IntAck) begin
                    next_state_s = SERVICE;
                end else begin
                    next_state_s = REQ;
                end
            end
            SERVICE: begin
                if (Retfie) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = SERVICE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register; IntReq is registered and high exactly while in REQ.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_r <= IDLE;
            IntReq  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            IntReq  <= (next_state_s == REQ);
        end
    end

    // Two-flop synchronizer for the INT pin plus one flop of edge history.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            pin_meta_r <= 1'b0;
            pin_sync_r <= 1'b0;
            pin_prev_r <= 1'b0;
        end else begin
            pin_meta_r <= INTPin;
            pin_sync_r <= pin_meta_r;
            pin_prev_r <= pin_sync_r;
        end
    end

    // Flag/enable registers: software writes override same-cycle hardware sets.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            gie_r  <= 1'b0;
            peie_r <= 1'b0;
            inte_r <= 1'b0;
            rbie_r <= 1'b0;
            intf_r <= 1'b0;
            rbif_r <= 1'b0;
            INTEDG <= 1'b1;
            PIR1   <= 8'h00;
            PIE1   <= 8'h00;
        end else begin
            if (ack_s) begin
                gie_r <= 1'b0;
            end else if (ret_s) begin
                gie_r <= 1'b1;
            end else if (wr_intcon_s) begin
                gie_r <= Data[7];
            end
            if (wr_intcon_s) begin
                peie_r <= Data[6];
                inte_r <= Data[4];
                rbie_r <= Data[3];
            end
            if (wr_intcon_s) begin
                intf_r <= Data[1];
            end else if (int_edge_s) begin
                intf_r <= 1'b1;
            end
            if (wr_intcon_s) begin
                rbif_r <= Data[0];
            end else if (RBChange) begin
                rbif_r <= 1'b1;
            end
            if (wr_intedg_s) begin
                INTEDG <= Data[6];
            end
            if (wr_pir1_s) begin
                PIR1 <= Data;
            end else begin
                PIR1 <= PIR1 | PeriphSet;
            end
            if (wr_pie1_s) begin
                PIE1 <= Data;
            end
        end
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have port Clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 SHALL have port nReset, input, 1 bit: synchronous, active-low reset, sampled on rising Clk.
REQ-003 SHALL have port Sync, input, 1 bit: one-Clk strobe marking each instruction-cycle boundary.
REQ-004 SHALL have ports Address (input, 9 bits), Data (input, 8 bits) and Latch (input, 1 bit): the register write bus; a write occurs on any Clk where Latch=1.
REQ-005 SHALL have ports T0IE and T0IF, inputs, 1 bit each: Timer0 enable and flag, owned by Timer0.
REQ-006 SHALL have port INTPin, input, 1 bit: asynchronous RB0/INT pin.
REQ-007 SHALL have port RBChange, input, 1 bit: one-Clk pulse on a PORTB change mismatch.
REQ-008 SHALL have port PeriphSet, input, 8 bits: per-bit one-Clk set pulses for PIR1.
REQ-009 SHALL have port IntAck, input, 1 bit: core pulse when it vectors to 0x004.
REQ-010 SHALL have port Retfie, input, 1 bit: core pulse when it executes RETFIE.
REQ-011 SHALL have port INTCON, output reg, 8 bits: {GIE,PEIE,T0IE,INTE,RBIE,T0IF,INTF,RBIF}; bits 5 and 2 are copies of the T0IE and T0IF inputs.
REQ-012 SHALL have ports PIR1 and PIE1, output reg, 8 bits each: peripheral flags and peripheral enables.
REQ-013 SHALL have port INTEDG, output reg, 1 bit: INT edge select (1 = rising, 0 = falling).
REQ-014 SHALL have port IntReq, output reg, 1 bit: interrupt request to the core.
REQ-015 SHALL have port Wake, output, 1 bit: combinational wake-from-sleep indication.

Function
REQ-016 SHALL perform an INTCON write when Latch=1 and Address[6:0]=7'h0B: GIE<=Data[7], PEIE<=Data[6], INTE<=Data[4], RBIE<=Data[3], INTF<=Data[1], RBIF<=Data[0].
REQ-017 SHALL perform an INTEDG write, INTEDG<=Data[6], when Latch=1 and Address[7:0]=8'h81.
REQ-018 SHALL write PIR1<=Data when Latch=1 and Address[7:0]=8'h0C, and PIE1<=Data when Latch=1 and Address[7:0]=8'h8C.
REQ-019 SHALL pass INTPin through a 2-flop synchronizer, then detect the edge selected by INTEDG on the synchronized signal; each detected edge sets INTF the following Clk.
REQ-020 SHALL set RBIF on an RBChange pulse, and set PIR1[n] on a PeriphSet[n] pulse.
REQ-021 SHALL let a register write take priority over a simultaneous hardware set of the same register; the hardware event is lost.
REQ-022 SHALL define Pending = (T0IE&T0IF) | (INTE&INTF) | (RBIE&RBIF) | (PEIE & |(PIE1&PIR1)).
REQ-023 SHALL drive Wake = Pending, independent of GIE.
REQ-024 SHALL implement a state machine with states IDLE, ARM, REQ and SERVICE:
- IDLE -> ARM when GIE=1 and Pending=1.
- ARM -> REQ on the next Sync=1 with Pending still 1.
- ARM -> IDLE if Pending or GIE drops before Sync.
- REQ: IntReq=1 until IntAck; on IntAck, GIE<=0, IntReq<=0, -> SERVICE.
- SERVICE: on Retfie, GIE<=1, -> IDLE.
REQ-025 SHALL hold IntReq at 1 only in state REQ, registered; latency from Pending rising to IntReq is at most one instruction cycle plus 1 Clk.
REQ-026 SHALL keep IntReq=1 in REQ even if flags are cleared before IntAck, because the request is committed.
REQ-027 SHALL give IntAck precedence over a same-Clk INTCON write to GIE, and give Retfie precedence over a same-Clk INTCON write to GIE.
REQ-028 SHALL ignore IntAck outside REQ, and ignore Retfie outside SERVICE.
REQ-029 SHALL NOT clear any flag in hardware; flags are cleared only by software writes.

Reset
REQ-030 SHALL, when nReset=0 at a rising Clk, clear GIE, PEIE, INTE, RBIE, INTF, RBIF, PIR1, PIE1, IntReq and the synchronizer/edge history, set INTEDG=1, and set the state to IDLE.
REQ-031 SHALL, on reset in REQ or SERVICE, drop IntReq the same edge and discard any outstanding request.

Verification
REQ-032 SHALL cover: write INTCON=8'hA0 (GIE and T0IE set from Timer0) with T0IF rising -> IntReq=1 within one Sync period plus 1 Clk; IntAck -> GIE=0, IntReq=0.
REQ-033 SHALL cover: INTEDG=0 with INTPin driven 1->0 -> INTF=1 exactly 3 Clk later; INTPin driven 0->1 -> INTF unchanged.
REQ-034 SHALL cover: PeriphSet[3] pulse with PIE1=8'h08, PEIE=1, GIE=0 -> PIR1=8'h08, Wake=1, IntReq=0.
REQ-035 SHALL cover: RBChange pulse on the same Clk as a write INTCON=8'h00 -> RBIF=0.
REQ-036 SHALL cover: Retfie in SERVICE with INTF still set and INTE=1 -> GIE=1, state IDLE, then IntReq=1 after the next Sync.
REQ-037 SHALL cover: nReset=0 while IntReq=1 -> IntReq=0, INTCON[7:6,4:3,1:0]=0, INTEDG=1.
